afe_tx_sched: RTL
=================

AFE_TX_SCHED -- requirements
Module: afe_tx_sched

Interface
REQ-001 Parameter: CH_B_EN, default 1, enables channel B capture; at 0, channel B inputs are ignored.
REQ-002 Parameter: TX_TIMEOUT, default 4095, maximum cycles to wait for tx_rdover before a frame is dropped.
REQ-003 Port: clk  in  1  system clock (div_clk domain); the only clock.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: afe_rdover_a  in  1  one-cycle pulse, channel A sample valid.
REQ-006 Port: led2_a, led1_a  in  24 each  signed ambient-corrected samples, channel A.
REQ-007 Port: afe_rdover_b  in  1  one-cycle pulse, channel B sample valid.
REQ-008 Port: led2_b, led1_b  in  24 each  signed ambient-corrected samples, channel B.
REQ-009 Port: uart_rdover  in  1  one-cycle pulse, UART finished the current frame.
REQ-010 Port: ovr_clr  in  1  clears the sticky error flags.
REQ-011 Port: dataReady  out  1  frame request to the UART.
REQ-012 Port: tx_data  out  48  frame to the UART.
REQ-013 Port: tx_ch  out  1  source of the current frame: 0 = A, 1 = B.
REQ-014 Port: ovr_a, ovr_b  out  1 each  sticky overrun flags.
REQ-015 Port: tx_tout  out  1  sticky UART timeout flag.

Function
REQ-016 Each channel SHALL have a one-entry holding buffer (48-bit frame plus a valid bit), loaded on the cycle after its afe_rdover pulse.
REQ-017 Frame format SHALL be {{3{led2[21]}}, led2[20:0], {3{led1[21]}}, led1[20:0]}; bits [23:22] of each input are discarded.
REQ-018 If afe_rdover arrives while that buffer is valid and not being granted in the same cycle, the buffer SHALL be overwritten with the newest frame and the channel's ovr flag set.
REQ-019 FSM states:
- IDLE
- SEND: dataReady=1.
- GAP: one cycle, dataReady=0.
REQ-020 IDLE->SEND SHALL occur when any buffer is valid; the granted buffer is copied to tx_data/tx_ch and its valid bit cleared in the same cycle.
REQ-021 If a capture and a grant of the same channel coincide, the new frame SHALL be stored with valid=1 and no overrun flagged.
REQ-022 Arbitration SHALL be round-robin: when both buffers are valid, the channel not served last wins; otherwise the sole valid channel wins.
REQ-023 Latency: afe_rdover at cycle n with the FSM in IDLE and the buffer empty -> buffer valid at n+1 -> dataReady=1 at n+2 with tx_data stable.
REQ-024 SEND->GAP SHALL occur on uart_rdover; tx_data and tx_ch SHALL be held constant throughout SEND.
REQ-025 A cycle counter SHALL run in SEND; on reaching TX_TIMEOUT without uart_rdover the frame is dropped, tx_tout is set, and the FSM goes SEND->GAP.
REQ-026 uart_rdover outside SEND SHALL be ignored.
REQ-027 GAP->IDLE is unconditional, guaranteeing dataReady low for at least one cycle between frames.
REQ-028 ovr_clr SHALL clear ovr_a, ovr_b and tx_tout; a set event in the same cycle wins over the clear.
REQ-029 With CH_B_EN=0, channel B's buffer SHALL never become valid and ovr_b SHALL stay 0.

Reset
REQ-030 While rst_n=0 at a clk edge the block SHALL load:
- FSM=IDLE, both valid bits 0, buffers 0;
- tx_data=0, tx_ch=0, dataReady=0;
- ovr_a=ovr_b=tx_tout=0, timeout counter 0;
- round-robin pointer=B, so A is served first.
REQ-031 Reset asserted mid-SEND SHALL abort the frame, dropping dataReady on the next edge; no partial state is kept.

Structure
REQ-032 Shared package afe_pkg SHALL hold the FSM state enumeration, the FRAME_W=48 constant and the channel-id encoding.
REQ-033 The per-channel holding buffer SHALL be a sub-module afe_frame_buf (capture, overwrite and overrun logic), instantiated twice.

Verification
REQ-034 Single frame: A pulse with led2_a=0x000123, led1_a=0xFFFFFE -> dataReady at n+2, tx_data=0x000123_FFFFFE, tx_ch=0; uart_rdover -> GAP then IDLE.
REQ-035 Simultaneous A and B pulses from reset -> A sent first, then B with tx_ch=1; no ovr flags.
REQ-036 Overrun: two A pulses while SEND is busy with a B frame -> ovr_a=1, the second A frame is sent; ovr_clr -> ovr_a=0.
REQ-037 Timeout with TX_TIMEOUT=8: no uart_rdover -> dataReady drops after 8 SEND cycles, tx_tout=1.
REQ-038 Width: led2_a=0x3FFFFF -> frame field 0xFFFFFF (sign bit 21 extended); led2_a=0x200000 -> 0xE00000.
REQ-039 Reset mid-SEND -> dataReady=0 next edge; a subsequent A pulse yields a normal frame with latency 2.

Source files
------------

// File: rtl/afe_pkg.sv
// Shared definitions for the AFE transmit scheduler.
//   FRAME_W    : width of one UART frame (two 24-bit sign-extended samples)
//   SAMPLE_W   : width of each raw AFE sample input
//   ch_e       : channel id encoding used on tx_ch (A = 0, B = 1)
//   tx_state_e : scheduler FSM states
//   pack_frame : builds a frame from the low 22 bits of led2/led1
package afe_pkg;

  localparam int unsigned FRAME_W  = 48;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned FIELD_W  = 22;

  typedef enum logic {
    ChA = 1'b0,
    ChB = 1'b1
  } ch_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } tx_state_e;

  // Bit 21 is the effective sign; it is replicated into the top three bits of each field.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [FIELD_W-1:0] led2,
                                                    input logic [FIELD_W-1:0] led1);
    return {{3{led2[21]}}, led2[20:0], {3{led1[21]}}, led1[20:0]};
  endfunction

endpackage

// File: rtl/afe_frame_buf.sv
// One-entry holding buffer for a single AFE channel.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   en           : (parameter EN) channel enable; when 0 captures are ignored
//   capture      : one-cycle sample-valid pulse from the AFE
//   led2, led1   : low 22 bits of the two ambient-corrected samples
//   grant        : scheduler takes the buffered frame this cycle
//   ovr_clr      : clears the sticky overrun flag
//   frame        : buffered 48-bit frame
//   valid        : buffer holds an unsent frame
//   ovr          : sticky overrun flag (a valid frame was overwritten)
module afe_frame_buf
  import afe_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic [FIELD_W-1:0] led2,
  input  logic [FIELD_W-1:0] led1,
  input  logic               grant,
  input  logic               ovr_clr,
  output logic [FRAME_W-1:0] frame,
  output logic               valid,
  output logic               ovr
);

  logic [FRAME_W-1:0] frame_d, frame_q;
  logic               valid_d, valid_q;
  logic               ovr_d, ovr_q;
  logic               cap;
  logic               ovr_set;

  assign cap = capture & EN;

  always_comb begin
    frame_d = frame_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (cap) begin
      frame_d = pack_frame(led2, led1);
      valid_d = 1'b1;
      // A frame being granted this cycle is not lost, so only an untaken one overruns.
      ovr_set = valid_q & ~grant;
    end else if (grant) begin
      valid_d = 1'b0;
    end
    // A new overrun wins over a clear in the same cycle.
    ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame = frame_q;
  assign valid = valid_q;
  assign ovr   = ovr_q;

endmodule

// File: rtl/afe_tx_sched.sv
// Schedules AFE sample frames from two channels onto a single UART.
// Each channel has a one-entry buffer; a round-robin arbiter picks a frame, holds it on
// tx_data/tx_ch with dataReady high until uart_rdover or a timeout, then idles one cycle.
// Ports:
//   clk, rst_n                   : clock and synchronous active-low reset
//   afe_rdover_a/b               : per-channel sample-valid pulses
//   led2_a/led1_a, led2_b/led1_b : 24-bit samples (bits [23:22] discarded)
//   uart_rdover                  : UART finished the current frame
//   ovr_clr                      : clears ovr_a, ovr_b and tx_tout
//   dataReady                    : frame request to the UART
//   tx_data, tx_ch               : frame and its source channel (0 = A, 1 = B)
//   ovr_a, ovr_b, tx_tout        : sticky overrun and timeout flags
module afe_tx_sched
  import afe_pkg::*;
#(
  parameter bit          CH_B_EN    = 1'b1,
  parameter int unsigned TX_TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                afe_rdover_a,
  input  logic [SAMPLE_W-1:0] led2_a,
  input  logic [SAMPLE_W-1:0] led1_a,
  input  logic                afe_rdover_b,
  input  logic [SAMPLE_W-1:0] led2_b,
  input  logic [SAMPLE_W-1:0] led1_b,
  input  logic                uart_rdover,
  input  logic                ovr_clr,
  output logic                dataReady,
  output logic [FRAME_W-1:0]  tx_data,
  output logic                tx_ch,
  output logic                ovr_a,
  output logic                ovr_b,
  output logic                tx_tout
);

  localparam int unsigned CNT_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  tx_state_e          state_d, state_q;
  logic [FRAME_W-1:0] tx_data_d, tx_data_q;
  ch_e                tx_ch_d, tx_ch_q;
  ch_e                last_d, last_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               tout_d, tout_q;
  logic               tout_set;

  logic               grant_a, grant_b;
  logic               valid_a, valid_b;
  logic [FRAME_W-1:0] frame_a, frame_b;

  logic unused_msbs;
  assign unused_msbs = ^{led2_a[23:22], led1_a[23:22], led2_b[23:22], led1_b[23:22]};

  afe_frame_buf #(
    .EN(1'b1)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (afe_rdover_a),
    .led2    (led2_a[FIELD_W-1:0]),
    .led1    (led1_a[FIELD_W-1:0]),
    .grant   (grant_a),
    .ovr_clr (ovr_clr),
    .frame   (frame_a),
    .valid   (valid_a),
    .ovr     (ovr_a)
  );

  afe_frame_buf #(
    .EN(CH_B_EN)
  ) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (afe_rdover_b),
    .led2    (led2_b[FIELD_W-1:0]),
    .led1    (led1_b[FIELD_W-1:0]),
    .grant   (grant_b),
    .ovr_clr (ovr_clr),
    .frame   (frame_b),
    .valid   (valid_b),
    .ovr     (ovr_b)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_ch_d   = tx_ch_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    tout_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_a || valid_b) begin
          // A wins if it is alone, or if both wait and B was served last.
          if (valid_a && (!valid_b || last_q == ChB)) begin
            grant_a   = 1'b1;
            tx_data_d = frame_a;
            tx_ch_d   = ChA;
            last_d    = ChA;
          end else begin
            grant_b   = 1'b1;
            tx_data_d = frame_b;
            tx_ch_d   = ChB;
            last_d    = ChB;
          end
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (uart_rdover) begin
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q == CNT_LAST) begin
          // TX_TIMEOUT send cycles elapsed without an acknowledge: drop the frame.
          cnt_d    = '0;
          tout_set = 1'b1;
          state_d  = StGap;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    tout_d = (tout_q & ~ovr_clr) | tout_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_ch_q   <= ChA;
      last_q    <= ChB;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_ch_q   <= tx_ch_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
    end
  end

  assign dataReady = (state_q == StSend);
  assign tx_data   = tx_data_q;
  assign tx_ch     = tx_ch_q;
  assign tx_tout   = tout_q;

endmodule
